projeto: RTL and testbench



---
 rtl/projeto_pkg.sv | 20 ++
 rtl/projeto_alu.sv | 39 +++
 rtl/projeto.sv | 136 +++++++++++++
 tb/tb_projeto.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/projeto_pkg.sv
// Shared types and constants for the quadratic polynomial evaluator.
package projeto_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    ADD1 = 3'd2,
    MUL2 = 3'd3,
    ADD2 = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } alu_op_e;

endpackage

// File: rtl/projeto_alu.sv
// Shared combinational datapath: wrapping signed multiply or add with overflow detection.
module projeto_alu
  import projeto_pkg::*;
#(
  parameter int WIDTH = projeto_pkg::WIDTH
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   sum_s;

  // Sign-extending both operands makes the low 2*WIDTH bits the exact signed product.
  always_comb begin
    prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    sum_s  = a_i + b_i;
    res_o  = '0;
    ovf_o  = 1'b0;
    case (op_i)
      OP_MUL: begin
        res_o = prod_s[WIDTH-1:0];
        ovf_o = (prod_s != {{WIDTH{prod_s[WIDTH-1]}}, prod_s[WIDTH-1:0]});
      end
      OP_ADD: begin
        res_o = sum_s;
        ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      default: begin
        res_o = '0;
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/projeto.sv
// Horner-form evaluator of A*X^2 + B*X + C: one shared ALU stepped by a small FSM,
// with an inicio/pronto handshake and an overflow flag accumulated over all four steps.
module projeto
  import projeto_pkg::*;
#(
  parameter int WIDTH = projeto_pkg::WIDTH
) (
  input  logic             ck,
  input  logic             inicio,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Resultado,
  output logic             pronto,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] br_q, br_d;
  logic [WIDTH-1:0] cr_q, cr_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             pronto_q, pronto_d;
  logic             ovf_out_q, ovf_out_d;

  alu_op_e          alu_op_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;

  projeto_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i  (alu_op_s),
    .a_i   (acc_q),
    .b_i   (alu_b_s),
    .res_o (alu_res_s),
    .ovf_o (alu_ovf_s)
  );

  // Next-state and datapath control; every step feeds the accumulator back through the ALU.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    xr_d      = xr_q;
    br_d      = br_q;
    cr_d      = cr_q;
    ov_d      = ov_q;
    res_d     = res_q;
    pronto_d  = pronto_q;
    ovf_out_d = ovf_out_q;
    alu_op_s  = OP_ADD;
    alu_b_s   = br_q;
    case (state_q)
      IDLE, DONE: begin
        if (inicio) begin
          xr_d     = X;
          br_d     = B;
          cr_d     = C;
          acc_d    = A;
          ov_d     = 1'b0;
          pronto_d = 1'b0;
          state_d  = MUL1;
        end else begin
          state_d = state_q;
        end
      end
      MUL1: begin
        alu_op_s = OP_MUL;
        alu_b_s  = xr_q;
        acc_d    = alu_res_s;
        ov_d     = ov_q | alu_ovf_s;
        state_d  = ADD1;
      end
      ADD1: begin
        alu_op_s = OP_ADD;
        alu_b_s  = br_q;
        acc_d    = alu_res_s;
        ov_d     = ov_q | alu_ovf_s;
        state_d  = MUL2;
      end
      MUL2: begin
        alu_op_s = OP_MUL;
        alu_b_s  = xr_q;
        acc_d    = alu_res_s;
        ov_d     = ov_q | alu_ovf_s;
        state_d  = ADD2;
      end
      ADD2: begin
        alu_op_s  = OP_ADD;
        alu_b_s   = cr_q;
        acc_d     = alu_res_s;
        ov_d      = ov_q | alu_ovf_s;
        res_d     = alu_res_s;
        ovf_out_d = ov_q | alu_ovf_s;
        pronto_d  = 1'b1;
        state_d   = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset aborts any job in flight.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      xr_q      <= '0;
      br_q      <= '0;
      cr_q      <= '0;
      ov_q      <= 1'b0;
      res_q     <= '0;
      pronto_q  <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      xr_q      <= xr_d;
      br_q      <= br_d;
      cr_q      <= cr_d;
      ov_q      <= ov_d;
      res_q     <= res_d;
      pronto_q  <= pronto_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign Resultado = res_q;
  assign pronto    = pronto_q;
  assign overflow  = ovf_out_q;

endmodule

// File: tb/tb_projeto.sv
// Self-checking bench for projeto: directed cases plus random jobs against an arithmetic model.
module tb_projeto;

  logic        ck = 1'b0;
  logic        inicio;
  logic        rst;
  logic [15:0] X, A, B, C;
  logic [15:0] Resultado;
  logic        pronto;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  projeto dut (
    .ck        (ck),
    .inicio    (inicio),
    .rst       (rst),
    .X         (X),
    .A         (A),
    .B         (B),
    .C         (C),
    .Resultado (Resultado),
    .pronto    (pronto),
    .overflow  (overflow)
  );

  always #5 ck = ~ck;

  function automatic bit fits16(input longint v);
    return (v >= -32768) && (v <= 32767);
  endfunction

  function automatic longint wrap16(input longint v);
    longint m;
    m = v % 65536;
    if (m < 0) m = m + 65536;
    if (m >= 32768) m = m - 65536;
    return m;
  endfunction

  // Reference: evaluate A*X^2+B*X+C in Horner order, wrapping to 16 bits after each step.
  task automatic model(input logic [15:0] a, b, c, x,
                       output logic [15:0] r, output logic o);
    longint av, bv, cv, xv, t;
    av = longint'($signed(a)); bv = longint'($signed(b));
    cv = longint'($signed(c)); xv = longint'($signed(x));
    o = 1'b0;
    t = av * xv; if (!fits16(t)) o = 1'b1; t = wrap16(t);
    t = t + bv;  if (!fits16(t)) o = 1'b1; t = wrap16(t);
    t = t * xv;  if (!fits16(t)) o = 1'b1; t = wrap16(t);
    t = t + cv;  if (!fits16(t)) o = 1'b1; t = wrap16(t);
    r = 16'(t);
  endtask

  // Drive one job; lat = number of edges after the sampling edge until pronto is seen.
  task automatic run_job(input logic [15:0] a, b, c, x, output int lat);
    @(negedge ck);
    A = a; B = b; C = c; X = x; inicio = 1'b1;
    @(posedge ck); #1;
    inicio = 1'b0;
    lat = 0;
    while (pronto !== 1'b1 && lat < 20) begin
      @(posedge ck); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; inicio = 1'b0; X = 16'd0; A = 16'd0; B = 16'd0; C = 16'd0;
    #12;
    total++;
    if (Resultado !== 16'd0 || pronto !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got res=%h pronto=%b ovf=%b want 0000 0 0", Resultado, pronto, overflow);
    end
    @(negedge ck); rst = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    total++;
    if (pronto !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got pronto=%b want 0", pronto);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5], tb [5], tc [5], tx [5], wr [5];
    logic        wo [5];
    int lat;
    ta = '{16'd38, 16'd38, 16'd256, 16'd1, 16'hFFFF};
    tb = '{16'd333, 16'd333, 16'd0, 16'd0, 16'd7};
    tc = '{16'd4902, 16'd5007, 16'd0, 16'hFFFF, 16'd100};
    tx = '{16'd23, 16'd23, 16'd256, 16'hFFFE, 16'd3};
    wr = '{16'h7F97, 16'h8000, 16'h0000, 16'd3, 16'd112};
    wo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_job(ta[i], tb[i], tc[i], tx[i], lat);
      total++;
      if (lat != 4) begin
        bad++;
        $display("FAIL directed_latency[%0d] got %0d edges want 4", i, lat);
      end
      total++;
      if (Resultado !== wr[i] || overflow !== wo[i]) begin
        bad++;
        $display("FAIL directed_result[%0d] got %h ovf=%b want %h ovf=%b", i, Resultado, overflow, wr[i], wo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, c, x, er;
    logic        eo;
    int lat;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        a = 16'($urandom_range(0, 200)) - 16'd100;
        b = 16'($urandom_range(0, 2000)) - 16'd1000;
        c = 16'($urandom_range(0, 2000)) - 16'd1000;
        x = 16'($urandom_range(0, 30)) - 16'd15;
      end else begin
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); x = 16'($urandom);
      end
      model(a, b, c, x, er, eo);
      run_job(a, b, c, x, lat);
      total++;
      if (lat != 4 || Resultado !== er || overflow !== eo) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h c=%h x=%h got %h ovf=%b lat=%0d want %h ovf=%b lat=4",
                 i, a, b, c, x, Resultado, overflow, lat, er, eo);
      end
    end
  endtask

  // inicio and new operands during MUL2 must not disturb the job in flight.
  task automatic test_busy_ignore();
    logic [15:0] er;
    logic        eo;
    int edges;
    model(16'd5, 16'd7, 16'd9, 16'd11, er, eo);
    @(negedge ck);
    A = 16'd5; B = 16'd7; C = 16'd9; X = 16'd11; inicio = 1'b1;
    @(posedge ck); #1; inicio = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    A = 16'd1000; B = 16'd2000; C = 16'd3000; X = 16'd4000; inicio = 1'b1;
    @(posedge ck); #1; inicio = 1'b0;
    edges = 3;
    while (pronto !== 1'b1 && edges < 20) begin
      @(posedge ck); #1;
      edges++;
    end
    total++;
    if (edges != 4 || Resultado !== er || overflow !== eo) begin
      bad++;
      $display("FAIL busy_ignore got %h ovf=%b lat=%0d want %h ovf=%b lat=4", Resultado, overflow, edges, er, eo);
    end
    repeat (4) @(posedge ck);
    #1;
    total++;
    if (pronto !== 1'b1 || Resultado !== er) begin
      bad++;
      $display("FAIL done_hold got pronto=%b res=%h want 1 %h", pronto, Resultado, er);
    end
  endtask

  task automatic test_restart_done();
    logic [15:0] er;
    logic        eo;
    int highs;
    model(16'd2, 16'd3, 16'd4, 16'd10, er, eo);
    @(negedge ck);
    A = 16'd2; B = 16'd3; C = 16'd4; X = 16'd10; inicio = 1'b1;
    @(posedge ck); #1; inicio = 1'b0;
    total++;
    if (pronto !== 1'b0) begin
      bad++;
      $display("FAIL restart_drop got pronto=%b want 0", pronto);
    end
    repeat (4) @(posedge ck);
    #1;
    total++;
    if (pronto !== 1'b1 || Resultado !== er || overflow !== eo) begin
      bad++;
      $display("FAIL restart_result got pronto=%b res=%h want 1 %h", pronto, Resultado, er);
    end
    // Continuous inicio from DONE: one pronto cycle every five edges.
    @(negedge ck); inicio = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ck); #1;
      if (pronto === 1'b1) highs++;
    end
    @(negedge ck); inicio = 1'b0;
    total++;
    if (highs != 2) begin
      bad++;
      $display("FAIL continuous_inicio got %0d pronto cycles want 2", highs);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge ck);
    A = 16'd3; B = 16'd4; C = 16'd5; X = 16'd6; inicio = 1'b1;
    @(posedge ck); #1; inicio = 1'b0;
    @(posedge ck); #2;
    rst = 1'b0;
    #1;
    total++;
    if (Resultado !== 16'd0 || pronto !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got res=%h pronto=%b ovf=%b want 0000 0 0", Resultado, pronto, overflow);
    end
    @(negedge ck); rst = 1'b1;
    repeat (8) @(posedge ck);
    #1;
    total++;
    if (pronto !== 1'b0 || Resultado !== 16'd0) begin
      bad++;
      $display("FAIL idle_after_abort got pronto=%b res=%h want 0 0000", pronto, Resultado);
    end
    run_job(16'd38, 16'd333, 16'd4902, 16'd23, lat);
    total++;
    if (lat != 4 || Resultado !== 16'h7F97) begin
      bad++;
      $display("FAIL post_reset_job got %h lat=%0d want 7f97 lat=4", Resultado, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_restart_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
